// File: rtl/spi_slave_if.sv
// -----------------------------------------------------------------------------
// spi_slave_if
//
// Register-bus bundle for the spi_slave peripheral.
//
//   i_stb    : bus strobe, held by the master until it sees o_ack
//   i_we     : 1 = write, 0 = read
//   i_dat_w  : write data
//   i_addr   : byte offset, i_addr[3:2] selects the register
//   o_dat_r  : read data, combinational from i_addr
//   o_ack    : one-cycle acknowledge
//
// Handshake: the master raises i_stb with stable i_we/i_addr/i_dat_w and holds
// them until it observes o_ack. The slave treats the single cycle where
// i_stb & ~o_ack as the access (all side effects happen there), and answers
// with o_ack high for exactly the following cycle. o_dat_r is valid during the
// o_ack cycle while i_addr is still held. Every offset is acknowledged.
// -----------------------------------------------------------------------------
interface spi_slave_if;
  logic        i_stb;
  logic        i_we;
  logic [31:0] i_dat_w;
  logic [3:0]  i_addr;
  logic [31:0] o_dat_r;
  logic        o_ack;

  modport master (
    output i_stb, i_we, i_dat_w, i_addr,
    input  o_dat_r, o_ack
  );

  modport slave (
    input  i_stb, i_we, i_dat_w, i_addr,
    output o_dat_r, o_ack
  );
endinterface

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// Memory-mapped SPI target port: mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit
// frames. The SPI pins are asynchronous to i_clk; they pass through
// SYNC_STAGES flops and edges are detected against a one-cycle-delayed copy.
// SCK must run at i_clk/8 or slower.
//
// Ports:
//   i_clk, i_rst   : system clock, synchronous active-high reset
//   bus            : register bus (spi_slave_if.slave)
//   i_ssn          : host chip select, active-low
//   i_sck          : host SPI clock
//   i_mosi         : host -> target data
//   o_miso         : target -> host data
//   o_miso_oe      : MISO output enable, high while a frame is active
//   o_irq          : interrupt (only with SPI_SLAVE_IRQ_EN defined)
//
// Registers (i_addr[3:2]):
//   0x00 DATA    R: rx_data       W: tx_buf[7:0] (clears tx_empty)
//   0x04 STATUS  R: {selected, overrun, tx_empty, rx_valid}
//                W: bit2 = 1 clears overrun
//   0x08 IRQ_EN  RW {ovr_ie, tx_ie, rx_ie} with SPI_SLAVE_IRQ_EN, else reads 0
//   0x0C         reads 0
//
// Optional feature macro: SPI_SLAVE_IRQ_EN (adds o_irq and the IRQ_EN register).
// -----------------------------------------------------------------------------
module spi_slave #(
  parameter int unsigned SYNC_STAGES = 2,     // at least 2
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  spi_slave_if.slave bus,
  input  logic       i_ssn,
  input  logic       i_sck,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_miso_oe
`ifdef SPI_SLAVE_IRQ_EN
  ,
  output logic       o_irq
`endif
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] ssn_sync_q, ssn_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   ssn_dly_q, ssn_dly_d;
  logic                   sck_dly_q, sck_dly_d;

  logic                   act_q, act_d;       // frame in progress (drives o_miso_oe)
  logic                   miso_q, miso_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [7:0]             rx_shift_q, rx_shift_d;
  logic [7:0]             tx_shift_q, tx_shift_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic [7:0]             tx_buf_q, tx_buf_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   tx_empty_q, tx_empty_d;
  logic                   overrun_q, overrun_d;
  logic                   ack_q, ack_d;
`ifdef SPI_SLAVE_IRQ_EN
  logic [2:0]             irq_en_q, irq_en_d;
  logic                   irq_q, irq_d;
`endif

  // ---------------------------------------------------------------------------
  // Synchronized pins and edge pulses
  // ---------------------------------------------------------------------------
  logic ssn_sync, sck_sync, mosi_sync;
  logic ssn_fall, ssn_rise, sck_rise, sck_fall;

  assign ssn_sync  = ssn_sync_q[SYNC_STAGES-1];
  assign sck_sync  = sck_sync_q[SYNC_STAGES-1];
  assign mosi_sync = mosi_sync_q[SYNC_STAGES-1];

  // The ssn chain resets to 0 (same as its delayed copy), so a falling edge
  // can only be seen after ssn has really been sampled high. A host that
  // keeps ssn low through reset is therefore ignored until its next frame.
  assign ssn_fall  = ssn_dly_q & ~ssn_sync;
  assign ssn_rise  = ~ssn_dly_q & ssn_sync;
  assign sck_rise  = sck_sync & ~sck_dly_q;
  assign sck_fall  = ~sck_sync & sck_dly_q;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic access, rd_data, wr_data, wr_status;
  logic [7:0] load_byte;

  assign access    = bus.i_stb & ~ack_q;
  assign rd_data   = access & ~bus.i_we & (bus.i_addr[3:2] == 2'd0);
  assign wr_data   = access &  bus.i_we & (bus.i_addr[3:2] == 2'd0);
  assign wr_status = access &  bus.i_we & (bus.i_addr[3:2] == 2'd1);

`ifdef SPI_SLAVE_IRQ_EN
  logic wr_irq_en;
  assign wr_irq_en = access & bus.i_we & (bus.i_addr[3:2] == 2'd2);
`endif

  // Byte presented to the host at frame start and after every completed byte.
  assign load_byte = tx_empty_q ? IDLE_BYTE : tx_buf_q;

  // Write-data bits above the byte lane and the sub-word offset are ignored.
  logic unused_bits;
  assign unused_bits = ^{bus.i_dat_w[31:8], bus.i_addr[1:0]};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    ssn_sync_d  = {ssn_sync_q[SYNC_STAGES-2:0], i_ssn};
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], i_sck};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
    ssn_dly_d   = ssn_sync;
    sck_dly_d   = sck_sync;

    act_d       = act_q;
    cnt_d       = cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    tx_buf_d    = tx_buf_q;
    rx_valid_d  = rx_valid_q;
    tx_empty_d  = tx_empty_q;
    overrun_d   = overrun_q;
    ack_d       = access;

    // Bus-side clears come first so that SPI-side sets in the same cycle win.
    if (rd_data) begin
      rx_valid_d = 1'b0;
    end
    if (wr_status && bus.i_dat_w[2]) begin
      overrun_d = 1'b0;
    end

    if (ssn_fall) begin
      act_d      = 1'b1;
      cnt_d      = 3'd0;
      tx_shift_d = load_byte;
      tx_empty_d = 1'b1;
    end else if (ssn_rise) begin
      // Partial byte is dropped; received data and flags are kept.
      act_d      = 1'b0;
      cnt_d      = 3'd0;
    end else if (act_q) begin
      if (sck_rise) begin
        rx_shift_d = {rx_shift_q[6:0], mosi_sync};
        cnt_d      = cnt_q + 3'd1;   // wraps to 0 after the 8th bit
        if (cnt_q == 3'd7) begin
          rx_data_d  = rx_shift_d;
          rx_valid_d = 1'b1;
          // A DATA read in this very cycle counts as having consumed the
          // previous byte, so no overrun is flagged.
          if (rx_valid_q && !rd_data) begin
            overrun_d = 1'b1;
          end
        end
      end else if (sck_fall) begin
        if (cnt_q != 3'd0) begin
          tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end else begin
          // First falling edge after a completed byte: present the next one.
          tx_shift_d = load_byte;
          tx_empty_d = 1'b1;
        end
      end
    end

    // A DATA write coinciding with a reload lands after it: the reload used
    // the old buffer, the new value waits for the following byte.
    if (wr_data) begin
      tx_buf_d   = bus.i_dat_w[7:0];
      tx_empty_d = 1'b0;
    end

    miso_d = act_d ? tx_shift_d[7] : 1'b0;
  end

`ifdef SPI_SLAVE_IRQ_EN
  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_irq_en) begin
      irq_en_d = bus.i_dat_w[2:0];
    end
    irq_d = (rx_valid_q & irq_en_q[0]) |
            (tx_empty_q & irq_en_q[1]) |
            (overrun_q  & irq_en_q[2]);
  end
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ssn_sync_q  <= '0;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      ssn_dly_q   <= 1'b0;
      sck_dly_q   <= 1'b0;
      act_q       <= 1'b0;
      miso_q      <= 1'b0;
      cnt_q       <= 3'd0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 8'h00;
      rx_data_q   <= 8'h00;
      tx_buf_q    <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_empty_q  <= 1'b1;
      overrun_q   <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      ssn_sync_q  <= ssn_sync_d;
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ssn_dly_q   <= ssn_dly_d;
      sck_dly_q   <= sck_dly_d;
      act_q       <= act_d;
      miso_q      <= miso_d;
      cnt_q       <= cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      tx_buf_q    <= tx_buf_d;
      rx_valid_q  <= rx_valid_d;
      tx_empty_q  <= tx_empty_d;
      overrun_q   <= overrun_d;
      ack_q       <= ack_d;
    end
  end

`ifdef SPI_SLAVE_IRQ_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      irq_en_q <= 3'd0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign o_irq = irq_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.o_dat_r = 32'h0;
    case (bus.i_addr[3:2])
      2'd0:    bus.o_dat_r = {24'h0, rx_data_q};
      2'd1:    bus.o_dat_r = {28'h0, act_q, overrun_q, tx_empty_q, rx_valid_q};
`ifdef SPI_SLAVE_IRQ_EN
      2'd2:    bus.o_dat_r = {29'h0, irq_en_q};
`endif
      default: bus.o_dat_r = 32'h0;
    endcase
  end

  assign bus.o_ack = ack_q;
  assign o_miso    = miso_q;
  assign o_miso_oe = act_q;

endmodule
